mux_n_para_1_arbitrado: RTL and testbench

Parametrised, registered N-to-1 multiplexer of WIDTH-bit channels, with valid/ready handshaking on every input and on the output. It supports two selection modes: fixed (the external selector S picks the channel) and round-robin (a fair arbiter picks among valid channels). It sits in front of the ULA operand/result paths where several producers share one consumer and a plain combinational mux can no longer be used.

---
 rtl/mux_pkg.sv | 12 +
 rtl/arbitro_round_robin.sv | 34 +++
 rtl/mux_n_para_1_arbitrado.sv | 107 ++++++++++
 tb/tb_mux_n_para_1_arbitrado.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared selection-mode encoding and select-width helper for the arbitrated N:1 mux.
package mux_pkg;

  localparam logic MODO_FIXO = 1'b0;
  localparam logic MODO_RR   = 1'b1;

  // Select width is never zero so N=1 still has a real S/GRANT port.
  function automatic int calc_sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbitro_round_robin.sv
// Combinational rotating-priority search: first requester at or after ptr, wrapping at N.
// Zero latency; no state, so backpressure is handled entirely by the caller.
module arbitro_round_robin #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             hit,
  output logic [SEL_W-1:0] idx
);

  int w_dist;
  int w_best;

  // Rotated distance from ptr; the closest requester wins.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    w_dist = 0;
    w_best = N;
    for (int c = 0; c < N; c++) begin
      if (req[c]) begin
        w_dist = (c >= int'(ptr)) ? (c - int'(ptr)) : (c + N - int'(ptr));
        if (w_dist < w_best) begin
          w_best = w_dist;
          idx    = SEL_W'(c);
          hit    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_para_1_arbitrado.sv
// Registered N:1 channel mux with fixed or round-robin selection; 1-cycle latency, 1 word/cycle.
// Y holds while VALID_OUT && !READY_OUT; READY_IN is combinational from READY_OUT and the selection.
module mux_n_para_1_arbitrado
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = calc_sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MODE,
  input  logic [SEL_W-1:0]   S,
  input  logic [N*WIDTH-1:0] D,
  input  logic [N-1:0]       VALID_IN,
  output logic [N-1:0]       READY_IN,
  output logic [WIDTH-1:0]   Y,
  output logic               VALID_OUT,
  input  logic               READY_OUT,
  output logic [SEL_W-1:0]   GRANT
);

  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic             w_rr_hit;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_fix_hit;
  logic             w_hit;
  logic [SEL_W-1:0] w_ch;
  logic [N-1:0]     w_rdy;
  logic             w_xfer;
  logic [WIDTH-1:0] w_dat;
  logic [SEL_W-1:0] w_ptr_nxt;

  assign w_load = !r_valid || READY_OUT;

  // Out-of-range selects only exist when N is not a power of two.
  generate
    if ((1 << SEL_W) > N) begin : g_sel_range
      assign w_fix_hit = (S < SEL_W'(N));
    end else begin : g_sel_full
      assign w_fix_hit = 1'b1;
    end
  endgenerate

  arbitro_round_robin #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req (VALID_IN),
    .ptr (r_ptr),
    .hit (w_rr_hit),
    .idx (w_rr_idx)
  );

  assign w_hit = (MODE == MODO_RR) ? w_rr_hit : w_fix_hit;
  assign w_ch  = (MODE == MODO_RR) ? w_rr_idx : S;

  always_comb begin
    w_rdy = '0;
    for (int c = 0; c < N; c++) begin
      if (!rst && w_load && w_hit && (w_ch == SEL_W'(c))) begin
        w_rdy[c] = 1'b1;
      end
    end
  end

  always_comb begin
    w_dat = '0;
    for (int c = 0; c < N; c++) begin
      if (w_rdy[c]) begin
        w_dat = D[c*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer    = |(w_rdy & VALID_IN);
  assign w_ptr_nxt = (w_ch == SEL_W'(N - 1)) ? '0 : (w_ch + SEL_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_y     <= w_dat;
        r_grant <= w_ch;
        if (MODE == MODO_RR) begin
          r_ptr <= w_ptr_nxt;
        end
      end
    end
  end

  assign READY_IN  = w_rdy;
  assign Y         = r_y;
  assign VALID_OUT = r_valid;
  assign GRANT     = r_grant;

endmodule

// File: tb/tb_mux_n_para_1_arbitrado.sv
// Bench for the arbitrated N:1 mux: directed table on N=4, wrap sequence on N=3,
// randomized scoreboard runs on N=5/WIDTH=16 and N=1/WIDTH=16.
module tb_mux_n_para_1_arbitrado;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // N=4, WIDTH=8
  logic        t4_mode = 1'b0;
  logic [1:0]  t4_s    = '0;
  logic [31:0] t4_d    = '0;
  logic [3:0]  t4_vin  = '0;
  logic [3:0]  t4_rdy;
  logic [7:0]  t4_y;
  logic        t4_vout;
  logic        t4_rout = 1'b1;
  logic [1:0]  t4_g;

  // N=3, WIDTH=8
  logic        t3_mode = 1'b0;
  logic [1:0]  t3_s    = '0;
  logic [23:0] t3_d    = 24'h222120;
  logic [2:0]  t3_vin  = '0;
  logic [2:0]  t3_rdy;
  logic [7:0]  t3_y;
  logic        t3_vout;
  logic        t3_rout = 1'b1;
  logic [1:0]  t3_g;

  // N=5, WIDTH=16
  logic        t5_mode = 1'b0;
  logic [2:0]  t5_s    = '0;
  logic [79:0] t5_d    = '0;
  logic [4:0]  t5_vin  = '0;
  logic [4:0]  t5_rdy;
  logic [15:0] t5_y;
  logic        t5_vout;
  logic        t5_rout = 1'b0;
  logic [2:0]  t5_g;

  // N=1, WIDTH=16
  logic        t1_mode = 1'b0;
  logic        t1_s    = 1'b0;
  logic [15:0] t1_d    = '0;
  logic        t1_vin  = 1'b0;
  logic        t1_rdy;
  logic [15:0] t1_y;
  logic        t1_vout;
  logic        t1_rout = 1'b0;
  logic        t1_g;

  mux_n_para_1_arbitrado #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .MODE(t4_mode), .S(t4_s), .D(t4_d), .VALID_IN(t4_vin),
    .READY_IN(t4_rdy), .Y(t4_y), .VALID_OUT(t4_vout), .READY_OUT(t4_rout), .GRANT(t4_g));

  mux_n_para_1_arbitrado #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .MODE(t3_mode), .S(t3_s), .D(t3_d), .VALID_IN(t3_vin),
    .READY_IN(t3_rdy), .Y(t3_y), .VALID_OUT(t3_vout), .READY_OUT(t3_rout), .GRANT(t3_g));

  mux_n_para_1_arbitrado #(.WIDTH(16), .N(5)) dut5 (
    .clk(clk), .rst(rst), .MODE(t5_mode), .S(t5_s), .D(t5_d), .VALID_IN(t5_vin),
    .READY_IN(t5_rdy), .Y(t5_y), .VALID_OUT(t5_vout), .READY_OUT(t5_rout), .GRANT(t5_g));

  mux_n_para_1_arbitrado #(.WIDTH(16), .N(1)) dut1 (
    .clk(clk), .rst(rst), .MODE(t1_mode), .S(t1_s), .D(t1_d), .VALID_IN(t1_vin),
    .READY_IN(t1_rdy), .Y(t1_y), .VALID_OUT(t1_vout), .READY_OUT(t1_rout), .GRANT(t1_g));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  vin;
    logic        rout;
    logic [3:0]  rdy;
    logic        vout;
    logic [7:0]  y;
    logic [1:0]  g;
  } vec_t;

  vec_t tv[19];

  task automatic step3(input logic mode, input logic [1:0] s, input logic [2:0] vin,
                       input logic [2:0] erdy, input logic evout, input logic [1:0] eg,
                       input logic [7:0] ey, input string nm);
    t3_mode = mode;
    t3_s    = s;
    t3_vin  = vin;
    #2;
    check({nm, "_rdy"}, t3_rdy, erdy);
    @(posedge clk);
    #1;
    check({nm, "_vout"}, t3_vout, evout);
    check({nm, "_grant"}, t3_g, eg);
    check({nm, "_y"}, t3_y, ey);
  endtask

  // Interface-level scoreboards for the randomized runs.
  typedef struct {
    logic [3:0]  ch;
    logic [15:0] dat;
  } sb_t;

  sb_t q5[$];
  sb_t q1[$];
  bit  run = 1'b0;
  int  wait5[5];
  int  max_wait5 = 0;
  int  pops5 = 0;
  int  pops1 = 0;

  always @(negedge clk) begin : sb_proc
    sb_t        e;
    logic       ld;
    logic [4:0] exp5;
    logic       xf;
    if (run) begin
      // Output side first: the word in Y was accepted in an earlier cycle.
      if (t5_vout && t5_rout) begin
        check("sb5_depth", q5.size(), 1);
        if (q5.size() != 0) begin
          e = q5.pop_front();
          check("sb5_y", t5_y, e.dat);
          check("sb5_grant", t5_g, e.ch);
          pops5++;
        end
      end
      if (t1_vout && t1_rout) begin
        check("sb1_depth", q1.size(), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("sb1_y", t1_y, e.dat);
          check("sb1_grant", t1_g, e.ch);
          pops1++;
        end
      end

      ld = !t5_vout || t5_rout;
      if (t5_mode == 1'b0) begin
        exp5 = (ld && t5_s < 3'd5) ? 5'(32'd1 << t5_s) : 5'd0;
        check("fix5_rdy", t5_rdy, exp5);
      end else begin
        check("rr5_rdy_any", |t5_rdy, ld && |t5_vin);
        check("rr5_rdy_subset", t5_rdy & ~t5_vin, 0);
        check("rr5_rdy_onehot", $countones(t5_rdy) <= 1, 1);
      end
      ld = !t1_vout || t1_rout;
      check("rdy1", t1_rdy, (t1_mode == 1'b0) ? (ld && !t1_s) : (ld && t1_vin));

      // Starvation: grants given to others while a channel stays valid.
      xf = |(t5_rdy & t5_vin);
      for (int c = 0; c < 5; c++) begin
        if (t5_mode == 1'b0 || !t5_vin[c]) begin
          wait5[c] = 0;
        end else if (xf) begin
          if (t5_rdy[c]) begin
            wait5[c] = 0;
          end else begin
            wait5[c]++;
            if (wait5[c] > max_wait5) max_wait5 = wait5[c];
          end
        end
      end

      for (int c = 0; c < 5; c++) begin
        if (t5_vin[c] && t5_rdy[c]) q5.push_back('{4'(c), t5_d[c*16 +: 16]});
      end
      if (t1_vin && t1_rdy) q1.push_back('{4'd0, t1_d});
    end
  end

  initial begin
    //        rst   mode  s     d              vin      rout  rdy      vout  y      g
    tv[0]  = '{1'b1, 1'b0, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{1'b0, 1'b0, 2'd2, 32'h13A51110, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tv[2]  = '{1'b0, 1'b0, 2'd3, 32'h13A51110, 4'b0100, 1'b1, 4'b1000, 1'b0, 8'hA5, 2'd2};
    tv[3]  = '{1'b0, 1'b0, 2'd0, 32'h13A5113C, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0};
    tv[4]  = '{1'b0, 1'b0, 2'd1, 32'h13A5553C, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[5]  = '{1'b0, 1'b0, 2'd1, 32'h13A5663C, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[6]  = '{1'b0, 1'b0, 2'd1, 32'h13A5773C, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[7]  = '{1'b0, 1'b0, 2'd1, 32'h13A5113C, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tv[8]  = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[9]  = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tv[10] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tv[11] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tv[12] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[13] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tv[14] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    tv[15] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[16] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    tv[17] = '{1'b0, 1'b0, 2'd3, 32'h13121110, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tv[18] = '{1'b0, 1'b1, 2'd0, 32'h13121110, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) begin
      rst     = tv[i].rst;
      t4_mode = tv[i].mode;
      t4_s    = tv[i].s;
      t4_d    = tv[i].d;
      t4_vin  = tv[i].vin;
      t4_rout = tv[i].rout;
      #2;
      check($sformatf("vec%0d_rdy", i), t4_rdy, tv[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_vout", i), t4_vout, tv[i].vout);
      check($sformatf("vec%0d_y", i), t4_y, tv[i].y);
      check($sformatf("vec%0d_grant", i), t4_g, tv[i].g);
    end

    // Mid-stream reset: outputs clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_vout", t4_vout, 0);
    check("arst_y", t4_y, 0);
    check("arst_grant", t4_g, 0);
    check("arst_rdy", t4_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("post_rst_rr_rdy", t4_rdy, 4'b0001);
    @(posedge clk);
    #1;
    check("post_rst_rr_grant", t4_g, 0);
    check("post_rst_rr_y", t4_y, 8'h10);
    t4_vin = '0;

    // N=3 round-robin skip and pointer wrap, then out-of-range select.
    step3(1'b1, 2'd0, 3'b100, 3'b100, 1'b1, 2'd2, 8'h22, "rr3_only2");
    step3(1'b1, 2'd0, 3'b101, 3'b001, 1'b1, 2'd0, 8'h20, "rr3_wrap");
    step3(1'b1, 2'd0, 3'b101, 3'b100, 1'b1, 2'd2, 8'h22, "rr3_next");
    step3(1'b1, 2'd0, 3'b101, 3'b001, 1'b1, 2'd0, 8'h20, "rr3_wrap2");
    step3(1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 2'd0, 8'h20, "fix3_oob");
    step3(1'b0, 2'd1, 3'b010, 3'b010, 1'b1, 2'd1, 8'h21, "fix3_s1");
    t3_vin = '0;

    // Randomized runs for N=5 and N=1.
    run = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      t5_mode = (cyc < 1000) ? 1'b1 : 1'($urandom_range(0, 1));
      t5_s    = 3'($urandom_range(0, 7));
      t5_vin  = 5'($urandom);
      t5_rout = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 5; k++) t5_d[k*16 +: 16] = 16'($urandom);
      t1_mode = 1'($urandom_range(0, 1));
      t1_s    = ($urandom_range(0, 7) == 0);
      t1_vin  = 1'($urandom_range(0, 1));
      t1_rout = 1'($urandom_range(0, 1));
      t1_d    = 16'($urandom);
      @(posedge clk);
      #1;
    end
    run = 1'b0;

    check("sb5_residue", q5.size(), t5_vout ? 1 : 0);
    check("sb1_residue", q1.size(), t1_vout ? 1 : 0);
    n_tests++;
    if (max_wait5 > 4) begin
      n_fail++;
      $display("FAIL rr5_starvation: max grants to others while valid %0d, limit 4", max_wait5);
    end
    n_tests++;
    if (pops5 < 200 || pops1 < 200) begin
      n_fail++;
      $display("FAIL sb_activity: delivered words n5=%0d n1=%0d, need at least 200 each", pops5, pops1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
